// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STEP      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_COLLECT,
        ST_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic int words_max(input int mem_depth);
        return mem_depth / BYTES_PER_WORD;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte packer: shifts bytes in MSB first and flags the byte
// that completes a word, presenting the full word combinationally with it.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word
);

    // Only the first three bytes of a word need storage; the fourth
    // arrives on byte_in in the same cycle the word is consumed.
    logic [DATA_WIDTH-BYTE_WIDTH-1:0] sr;
    logic [1:0]                       cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= {sr[DATA_WIDTH-2*BYTE_WIDTH-1:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    assign word_ready = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {sr, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Program loader: length-checked byte stream from an FWFT FIFO into
// 32-bit instruction-memory writes. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ST_IDLE  | out of reset, waiting for start
// ST_LEN   | pop and validate the word-count header
// ST_COLLECT | pop payload bytes into the word assembler
// ST_WRITE | one-cycle instruction-memory write
// ST_CHECK | pop trailing XOR byte and compare (checksum builds only)
// ST_DONE  | image loaded, processor released
// ST_ERROR | load rejected, processor stays held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fifo_empty,
    input  logic [BYTE_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [BYTE_WIDTH-1:0] dir,
    output logic                  we,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold
);

    localparam logic [BYTE_WIDTH-1:0] WMAX = BYTE_WIDTH'(words_max(MEM_DEPTH));

    state_t                  state;
    logic [BYTE_WIDTH-1:0]   n_words;
    logic [BYTE_WIDTH-1:0]   word_cnt;
    logic [BYTE_WIDTH-1:0]   word_cnt_nxt;
    logic                    pop;
    logic                    start_ok;
    logic                    word_ready;
    logic [DATA_WIDTH-1:0]   word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0]   xor_acc;
`endif

    always_comb begin
        pop = 1'b0;
        case (state)
            ST_LEN, ST_COLLECT: pop = !fifo_empty;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK:           pop = !fifo_empty;
`endif
            default:            pop = 1'b0;
        endcase
    end

    assign fifo_rd_en   = pop;
    assign start_ok     = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                    (state == ST_ERROR));
    assign word_cnt_nxt = word_cnt + BYTE_WIDTH'(1);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .shift_en   (pop && (state == ST_COLLECT)),
        .byte_in    (fifo_dout),
        .word_ready (word_ready),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            n_words  <= '0;
            word_cnt <= '0;
            data_in  <= '0;
            dir      <= '0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc  <= '0;
`endif
        end else begin
            we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        state    <= ST_LEN;
                        word_cnt <= '0;
                        dir      <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_acc  <= '0;
`endif
                    end
                end

                ST_LEN: begin
                    if (!fifo_empty) begin
                        if (fifo_dout == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= ST_CHECK;
`else
                            state    <= ST_DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (fifo_dout > WMAX) begin
                            state <= ST_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            n_words <= fifo_dout;
                            state   <= ST_COLLECT;
                        end
                    end
                end

                ST_COLLECT: begin
                    if (pop) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_acc <= xor_acc ^ fifo_dout;
`endif
                        if (word_ready) begin
                            data_in <= word;
                            we      <= 1'b1;
                            state   <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    word_cnt <= word_cnt_nxt;
                    if (word_cnt_nxt == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
`else
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        // Only step when another word follows, so a full
                        // 64-word image leaves dir at its last address.
                        dir   <= dir + BYTE_WIDTH'(ADDR_STEP);
                        state <= ST_COLLECT;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (!fifo_empty) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        if (fifo_dout == xor_acc) begin
                            state    <= ST_DONE;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
